// File: rtl/fpmul_sched.sv
// fpmul_sched: round-robin scheduler sharing one combinational binary32
// multiplier between two requesters, with a tagged, backpressured response.
// Optional macro FPMUL_SCHED_ZERO_BYPASS_EN: zero-operand products skip MUL.
module fpmul_sched #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [31:0]        req0_a,
    input  logic [31:0]        req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [31:0]        req1_a,
    input  logic [31:0]        req1_b,
    output logic               req1_ready,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [31:0]        mul_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [31:0]        rsp_y,
    output logic               busy,
    output logic [COUNT_W-1:0] cnt0,
    output logic [COUNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [31:0]        op_a_q, op_a_d;
    logic [31:0]        op_b_q, op_b_d;
    logic               op_id_q, op_id_d;
    logic [31:0]        rsp_y_q, rsp_y_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;
    logic [COUNT_W-1:0] cnt0_q, cnt0_d;
    logic [COUNT_W-1:0] cnt1_q, cnt1_d;

    logic               grant0, grant1;
    logic [31:0]        acc_a, acc_b;
    logic               bypass;
    logic               rsp_fire;

    // Round-robin grant in IDLE: on a tie the requester not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_q);
            grant1 = req1_valid && (!req0_valid || !last_q);
        end
        acc_a = grant1 ? req1_a : req0_a;
        acc_b = grant1 ? req1_b : req0_b;
`ifdef FPMUL_SCHED_ZERO_BYPASS_EN
        bypass = (acc_a[30:0] == 31'd0) || (acc_b[30:0] == 31'd0);
`else
        bypass = 1'b0;
`endif
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_fire   = rsp_valid_q && rsp_ready;

    // Next-state logic for the IDLE -> MUL -> RESP sequence and counters.
    // rsp_valid is registered, so it rises one edge after RESP is entered
    // and drops on the handshake edge together with the return to IDLE.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_id_d = op_id_q;
        rsp_y_d = rsp_y_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    last_d  = grant1;
                    op_id_d = grant1;
                    if (bypass) begin
                        // Signed zero result; multiplier operands untouched.
                        rsp_y_d = {acc_a[31] ^ acc_b[31], 31'd0};
                        state_d = RESP;
                    end else begin
                        op_a_d  = acc_a;
                        op_b_d  = acc_b;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                rsp_y_d = mul_y;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_d = IDLE;
                    if (op_id_q) cnt1_d = cnt1_q + COUNT_W'(1);
                    else         cnt0_d = cnt0_q + COUNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_q == RESP) && !rsp_fire;
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= 1'b0;
            rsp_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign mul_a     = op_a_q;
    assign mul_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = op_id_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_fpmul_sched.sv
// Scoreboard bench for fpmul_sched with a behavioural binary32 multiplier.
module tb_fpmul_sched;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0]   req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          req0_ready, req1_ready;
    logic [31:0]   mul_a, mul_b, mul_y;
    logic          rsp_valid, rsp_id;
    logic          rsp_ready = 1'b1;
    logic [31:0]   rsp_y;
    logic          busy;
    logic [CW-1:0] cnt0, cnt1;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic          exp_id_q[$];
    logic [31:0]   exp_y_q[$];
    logic          mon_id;
    logic [31:0]   mon_y;

    always #5 clk = ~clk;

    fpmul_sched #(.COUNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Truncating multiplier for normal operands, signed zero for zero operands.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, e[7:0], m};
    endfunction

    assign mul_y = fmul(mul_a, mul_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every response handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_y_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got id %0d y %h, required no response", rsp_id, rsp_y);
            end else begin
                mon_id = exp_id_q.pop_front();
                mon_y  = exp_y_q.pop_front();
                check("sb_rsp_id", 32'(rsp_id), 32'(mon_id));
                check("sb_rsp_y", rsp_y, mon_y);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Raise valid, wait for grant, return #1 after the accepting edge.
    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b, input bit push);
        int t;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
        t = 0;
        while (1) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) break;
            t++;
            if (t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL grant_timeout: got no ready for requester %0d, required ready", id);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        if (push) begin
            exp_id_q.push_back(id[0]);
            exp_y_q.push_back(fmul(a, b));
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy || rsp_valid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL idle_timeout: got busy %0d, required 0", busy);
                break;
            end
        end
    endtask

    initial begin
        logic [31:0]   prev_a;
        logic [CW-1:0] c1;
        int            t;

        // Reset state
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cnt0", 32'(cnt0), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);

        // Single request: 2.0 * 3.0, latency N+2
        send(0, 32'h40000000, 32'h40400000, 1);
        check("t1_valid_n", 32'(rsp_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("t1_valid_n1", 32'(rsp_valid), 32'd0);
        check("t1_mul_a", mul_a, 32'h40000000);
        @(posedge clk); #1;
        check("t1_valid_n2", 32'(rsp_valid), 32'd1);
        check("t1_rsp_y", rsp_y, 32'h40C00000);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_n3", 32'(rsp_valid), 32'd0);
        check("t1_cnt0", 32'(cnt0), 32'd1);
        wait_idle();

        // Simultaneous requests after reset: requester 0 first
        do_reset();
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
        req1_valid = 1'b1; req1_a = 32'h40000000; req1_b = 32'h40000000;
        #1;
        check("t2_ready0", 32'(req0_ready), 32'd1);
        check("t2_ready1", 32'(req1_ready), 32'd0);
        send(0, 32'h3FC00000, 32'h3FC00000, 1);
        send(1, 32'h40000000, 32'h40000000, 1);
        wait_idle();
        check("t2_cnt0", 32'(cnt0), 32'd1);
        check("t2_cnt1", 32'(cnt1), 32'd1);

        // Tie with last = 0: requester 1 wins, requester 0 follows
        send(0, 32'h3F800000, 32'h3F800000, 1);
        wait_idle();
        req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40A00000;
        req1_valid = 1'b1; req1_a = 32'h40400000; req1_b = 32'h40400000;
        #1;
        check("t3_ready0", 32'(req0_ready), 32'd0);
        check("t3_ready1", 32'(req1_ready), 32'd1);
        send(1, 32'h40400000, 32'h40400000, 1);
        send(0, 32'h3F800000, 32'h40A00000, 1);
        wait_idle();
        check("t3_cnt0", 32'(cnt0), 32'd3);
        check("t3_cnt1", 32'(cnt1), 32'd2);

        // Backpressure: 5 cycles of rsp_ready low in RESP
        rsp_ready = 1'b0;
        send(1, 32'h3F800000, 32'hC0000000, 1);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check("t4_valid_seen", 32'(rsp_valid), 32'd1);
        c1 = cnt1;
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
        repeat (5) begin
            @(posedge clk); #1;
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check("t4_hold_y", rsp_y, 32'hC0000000);
            check("t4_hold_id", 32'(rsp_id), 32'd1);
            check("t4_no_ready0", 32'(req0_ready), 32'd0);
            check("t4_hold_cnt1", 32'(cnt1), 32'(c1));
        end
        rsp_ready = 1'b1;
        #1;
        check("t4_no_ready_hs", 32'(req0_ready), 32'd0);
        @(posedge clk); #1;
        check("t4_cnt1_inc", 32'(cnt1), 32'(c1 + CW'(1)));
        check("t4_valid_drop", 32'(rsp_valid), 32'd0);
        send(0, 32'h40000000, 32'h40000000, 1);
        wait_idle();
        check("t4_cnt1_once", 32'(cnt1), 32'(c1 + CW'(1)));

        // Zero operand: -0 * 3.0
        prev_a = mul_a;
        send(0, 32'h80000000, 32'h40400000, 1);
`ifdef FPMUL_SCHED_ZERO_BYPASS_EN
        check("t5_mul_a_kept", mul_a, prev_a);
        @(posedge clk); #1;
        check("t5_valid_n1", 32'(rsp_valid), 32'd1);
        check("t5_rsp_y", rsp_y, 32'h80000000);
`else
        check("t5_mul_a", mul_a, 32'h80000000);
        @(posedge clk); #1;
        check("t5_valid_n1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t5_valid_n2", 32'(rsp_valid), 32'd1);
        check("t5_rsp_y", rsp_y, 32'h80000000);
`endif
        wait_idle();

        // Reset asserted during MUL discards the operation
        send(1, 32'h40000000, 32'h40400000, 0);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_cnt0", 32'(cnt0), 32'd0);
        check("t6_cnt1", 32'(cnt1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        end
        send(0, 32'h40400000, 32'h40400000, 1);
        wait_idle();
        check("t6_cnt0_after", 32'(cnt0), 32'd1);
        check("t6_cnt1_after", 32'(cnt1), 32'd0);

        check("sb_empty", 32'(exp_y_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required $finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
